seg7_scan_driver: RTL

Time-multiplexed driver for an N-digit seven-segment display with a shared segment bus and one enable per digit.
- Takes a packed hex value, per-digit decimal points and control flags.
- Scans the digits at a programmable rate, with an inter-digit blanking gap to stop ghosting.
- Applies new values only at frame boundaries, so the display never tears.
- Sits between the numeric datapath and the board-level display pins; segment and anode polarity are parameters, so common-anode and common-cathode boards share one block.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_driver.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: hex glyph table and polarity helper.
package seg7_pkg;

   localparam int SEG_W = 7;

   // Active-high {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
   localparam logic [SEG_W-1:0] HEX_GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [SEG_W-1:0] seg_pol(
      input logic [SEG_W-1:0] glyph,
      input logic             active_low
   );
      return active_low ? ~glyph : glyph;
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-seven-segment decoder, active-high glyph output.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0]       digit_i,
   output logic [SEG_W-1:0] glyph_o
);

   assign glyph_o = HEX_GLYPH[digit_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment scanner with blanking gap,
// frame-synchronous value update and leading-zero suppression.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int BLANK_CYCLES   = 500,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic                    load,
   input  logic                    enable,
   input  logic                    lz_en,
   output logic [SEG_W-1:0]        seg,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int VAL_W = 4 * NUM_DIGITS;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
   localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [VAL_W-1:0]      sh_val_q, sh_val_d;
   logic [VAL_W-1:0]      disp_val_q, disp_val_d;
   logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
   logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
   logic                  pend_q, pend_d;
   logic [SEG_W-1:0]      seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  fd_q;

   logic                  slot_end;
   logic                  wrap;
   logic [IDX_W-1:0]      top_nz;
   logic                  lz_blank;
   logic [3:0]            nib;
   logic [SEG_W-1:0]      glyph;
   logic [NUM_DIGITS-1:0] sel;

   assign slot_end = (cnt_q == CNT_LAST);
   assign wrap     = slot_end && (idx_q == IDX_LAST);
   assign nib      = disp_val_q[idx_q*4 +: 4];

   seg7_hex_decode u_dec (
      .digit_i (nib),
      .glyph_o (glyph)
   );

   always_comb begin
      top_nz = '0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (disp_val_q[4*i +: 4] != 4'h0) top_nz = IDX_W'(i);
      end
   end

   assign lz_blank = lz_en && (idx_q > top_nz);

   always_comb begin
      sel        = '0;
      sel[idx_q] = 1'b1;
   end

   always_comb begin
      cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
      idx_d      = idx_q;
      sh_val_d   = sh_val_q;
      sh_dp_d    = sh_dp_q;
      disp_val_d = disp_val_q;
      disp_dp_d  = disp_dp_q;
      pend_d     = pend_q;
      if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      if (wrap && pend_q) begin
         disp_val_d = sh_val_q;
         disp_dp_d  = sh_dp_q;
         pend_d     = 1'b0;
      end
      // A load on the wrap edge bypasses the shadow so it is not a frame late.
      if (load) begin
         sh_val_d = value;
         sh_dp_d  = dp;
         pend_d   = !wrap;
         if (wrap) begin
            disp_val_d = value;
            disp_dp_d  = dp;
         end
      end
   end

   always_comb begin
      seg_d = seg_pol(lz_blank ? '0 : glyph, SEG_INV);
      dp_d  = disp_dp_q[idx_q] ^ SEG_INV;
      if (!enable || cnt_q < BLANK_END) an_d = {NUM_DIGITS{AN_INV}};
      else an_d = sel ^ {NUM_DIGITS{AN_INV}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         sh_val_q   <= '0;
         sh_dp_q    <= '0;
         disp_val_q <= '0;
         disp_dp_q  <= '0;
         pend_q     <= 1'b0;
         seg_q      <= {SEG_W{SEG_INV}};
         dp_q       <= SEG_INV;
         an_q       <= {NUM_DIGITS{AN_INV}};
         fd_q       <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         sh_val_q   <= sh_val_d;
         sh_dp_q    <= sh_dp_d;
         disp_val_q <= disp_val_d;
         disp_dp_q  <= disp_dp_d;
         pend_q     <= pend_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
         fd_q       <= wrap;
      end
   end

   assign seg        = seg_q;
   assign dp_out     = dp_q;
   assign an         = an_q;
   assign frame_done = fd_q;

endmodule
